// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg: shared front-end types for the fetch sequencer
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_pc_seq      = 2'd0,
    e_pc_hold     = 2'd1,
    e_pc_redirect = 2'd2,
    e_pc_rebase   = 2'd3
  } bp_fe_next_pc_sel_e;

  typedef enum logic [2:0] {
    e_wait   = 3'd0,
    e_refill = 3'd1,
    e_run    = 3'd2,
    e_stall  = 3'd3,
    e_rebase = 3'd4
  } bp_fe_seq_state_e;

endpackage

// File: rtl/bp_fe_credit_counter.sv
// bp_fe_credit_counter: saturating-checked up/down credit counter with clear-to-full
module bp_fe_credit_counter #(
  parameter int max_p   = 8,
  parameter int width_p = $clog2(max_p + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic               dec,
  output logic [width_p-1:0] cnt,
  output logic [width_p-1:0] cnt_next
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_p);

  // clear wins over any same-cycle inc/dec; inc and dec together cancel
  always_comb
    cnt_next = clr ? max_lp
             : (inc & ~dec) ? cnt + 1'b1
             : (dec & ~inc) ? cnt - 1'b1
             : cnt;

  // credit register, full after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= max_lp;
    else        cnt <= cnt_next;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc && !dec && !clr && cnt == max_lp));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec && !inc && !clr && cnt == '0));

endmodule

// File: rtl/bp_fe_fetch_sequencer.sv
// bp_fe_fetch_sequencer: fetch-enable and next-PC select control for the IF1/IF2 pipeline
module bp_fe_fetch_sequencer
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p   = 39,
  parameter int cinstr_width_p  = 16,
  parameter int fetch_ptr_p     = 2,
  parameter int fq_credits_p    = 8,
  parameter int refill_cycles_p = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              cmd_v_i,
  input  logic [vaddr_width_p-1:0]          cmd_pc_i,
  input  logic [fetch_ptr_p-1:0]            cmd_count_i,
  input  logic [cinstr_width_p-1:0]         cmd_instr_i,
  output logic                              cmd_yumi_o,
  input  logic                              fq_clear_i,
  input  logic                              fq_credit_return_i,
  input  logic                              fetch_instr_v_i,
  input  logic                              fetch_catchup_i,
  input  logic                              fetch_rebase_i,
  input  logic [vaddr_width_p-1:0]          fetch_pc_i,
  output logic                              redirect_v_o,
  output logic [vaddr_width_p-1:0]          redirect_pc_o,
  output logic [fetch_ptr_p-1:0]            redirect_count_o,
  output logic [cinstr_width_p-1:0]         redirect_instr_o,
  output logic                              fetch_ready_then_o,
  output logic [1:0]                        next_pc_sel_o,
  output logic [vaddr_width_p-1:0]          rebase_pc_o,
  output logic [$clog2(fq_credits_p+1)-1:0] credits_o
);

  localparam int cw_lp = $clog2(fq_credits_p + 1);
  localparam int rw_lp = (refill_cycles_p > 1) ? $clog2(refill_cycles_p) : 1;
  localparam logic [rw_lp-1:0] refill_init_lp = rw_lp'(refill_cycles_p - 1);

  bp_fe_seq_state_e         state, state_n;
  logic [rw_lp-1:0]         refill, refill_n;
  logic [vaddr_width_p-1:0] rebase_pc;
  logic [cw_lp-1:0]         credits, credits_n;
  logic                     cmd, take_rebase;

  // gating with reset keeps every valid low while reset is asserted
  assign cmd         = cmd_v_i & reset_n_i;
  assign take_rebase = ~cmd & (state == e_run) & fetch_rebase_i;

  bp_fe_credit_counter #(.max_p(fq_credits_p), .width_p(cw_lp)) credit_counter (
    .clk      (clk_i),
    .rst_n    (reset_n_i),
    .clr      (fq_clear_i),
    .inc      (fq_credit_return_i),
    .dec      (fetch_instr_v_i),
    .cnt      (credits),
    .cnt_next (credits_n)
  );

  // state and refill counter registers
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state  <= e_wait;
      refill <= '0;
    end else begin
      state  <= state_n;
      refill <= refill_n;
    end

  // capture the realigner PC to refetch when a rebase is taken
  always_ff @(posedge clk_i)
    if (take_rebase) rebase_pc <= fetch_pc_i;

  // next state: a command always wins, otherwise credits decide run vs stall
  always_comb begin
    state_n  = state;
    refill_n = refill;
    if (cmd) begin
      state_n  = e_refill;
      refill_n = refill_init_lp;
    end else
      case (state)
        e_refill:
          if (refill == '0) state_n = (credits_n != '0) ? e_run : e_stall;
          else              refill_n = refill - 1'b1;
        e_run:              state_n = fetch_rebase_i ? e_rebase : (credits_n == '0) ? e_stall : e_run;
        e_rebase, e_stall:  state_n = (credits_n == '0) ? e_stall : e_run;
        default:            state_n = state;
      endcase
  end

  // outputs: redirect path is combinational from the command
  always_comb begin
    cmd_yumi_o         = cmd;
    redirect_v_o       = cmd;
    fetch_ready_then_o = ~cmd & (state == e_run);
    next_pc_sel_o      = cmd ? e_pc_redirect
                       : (state != e_run) ? e_pc_seq
                       : fetch_rebase_i ? e_pc_rebase
                       : fetch_catchup_i ? e_pc_hold
                       : e_pc_seq;
  end

  assign redirect_pc_o    = cmd_pc_i;
  assign redirect_count_o = cmd_count_i;
  assign redirect_instr_o = cmd_instr_i;
  assign rebase_pc_o      = rebase_pc;
  assign credits_o        = credits;

  a_fetch_only_when_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(fetch_instr_v_i && !fetch_ready_then_o));

endmodule

// File: doc/bp_fe_fetch_sequencer.md
Name: bp_fe_fetch_sequencer

Overview:
- Front-end fetch sequencer: owns the fetch-enable and next-PC select for the IF1/IF2 pipeline that feeds the 32-bit realigner.
- Turns backend redirect commands into realigner/I$ redirect pulses, then drains the pipeline for a fixed refill window.
- Inserts a bubble on a realigner rebase, holds the PC on a catchup, and throttles fetch on fetch-queue credits.
- Sits between the backend command interface, the PC generator and the realigner.

Parameters:
- vaddr_width_p, 39, virtual address width
- cinstr_width_p, 16, compressed parcel width
- fetch_ptr_p, 2, width of the parcel count field
- fq_credits_p, 8, fetch-queue entries; one credit per valid fetch packet
- refill_cycles_p, 2, post-redirect drain cycles (≥1)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- cmd_v_i  in  1  backend redirect command valid
- cmd_pc_i  in  vaddr_width_p  redirect target PC
- cmd_count_i  in  fetch_ptr_p  resume parcel count (0 = no partial instruction)
- cmd_instr_i  in  cinstr_width_p  resume low parcel
- cmd_yumi_o  out  1  command consumed
- fq_clear_i  in  1  backend flushed the fetch queue
- fq_credit_return_i  in  1  one fetch-queue entry freed
- fetch_instr_v_i  in  1  realigner emitted a packet
- fetch_catchup_i  in  1  realigner catchup request
- fetch_rebase_i  in  1  realigner rebase request
- fetch_pc_i  in  vaddr_width_p  realigner output PC
- redirect_v_o  out  1  redirect pulse to realigner and I$
- redirect_pc_o  out  vaddr_width_p  redirect PC
- redirect_count_o  out  fetch_ptr_p  resume count
- redirect_instr_o  out  cinstr_width_p  resume parcel
- fetch_ready_then_o  out  1  IF2 may produce this cycle
- next_pc_sel_o  out  2  0 seq, 1 hold, 2 redirect, 3 rebase
- rebase_pc_o  out  vaddr_width_p  PC to refetch on a rebase
- credits_o  out  $clog2(fq_credits_p+1)  free credits (debug)

Behaviour:
- Reset (async, reset_n_i=0):
  - state = e_wait, credits = fq_credits_p, refill counter = 0.
  - All valid outputs 0; next_pc_sel_o = 0.
  - rebase_pc_o and redirect payloads are don't-care.
- States: e_wait, e_refill, e_run, e_stall, e_rebase.
  - e_wait: fetch_ready_then_o = 0; waiting for the first command after reset.
- Command acceptance:
  - cmd_yumi_o = cmd_v_i in every state; zero latency; a command always wins.
  - While accepting, the redirect path is combinational:
    - redirect_v_o = 1; redirect_pc/count/instr = cmd_*.
    - next_pc_sel_o = 2; fetch_ready_then_o = 0.
  - Next state is e_refill with counter = refill_cycles_p-1.
  - A command mid-refill restarts the counter.
- e_refill:
  - fetch_ready_then_o = 0; next_pc_sel_o = 0.
  - Counter decrements each cycle; at 0, go to e_run if credits ≠ 0, else e_stall.
- e_run:
  - fetch_ready_then_o = 1 when there is no command.
  - Priority: cmd > rebase > catchup > seq.
  - fetch_rebase_i: next_pc_sel_o = 3; rebase_pc_o = fetch_pc_i registered; go to e_rebase.
  - fetch_catchup_i (no rebase): next_pc_sel_o = 1; stay in e_run.
  - Otherwise next_pc_sel_o = 0.
- e_rebase:
  - One bubble: fetch_ready_then_o = 0; rebase_pc_o is held.
  - Then go to e_run, or e_stall if credits = 0.
- Credits:
  - Decrement on fetch_instr_v_i; increment on fq_credit_return_i; both in one cycle = no change.
  - fq_clear_i sets credits to fq_credits_p. It overrides the same-cycle decrement and increment.
  - Overflow or underflow is an assertion failure.
  - In e_run, if the next credit count is 0, go to e_stall.
  - e_stall: fetch_ready_then_o = 0; go to e_run when credits become nonzero.
- fetch_instr_v_i while fetch_ready_then_o = 0 is an assertion failure.
- Reset asserted mid-redirect aborts to e_wait; no redirect pulse survives.

Decomposition:
- bp_fe_pkg gains:
  - bp_fe_next_pc_sel_e {e_pc_seq, e_pc_hold, e_pc_redirect, e_pc_rebase}
  - bp_fe_seq_state_e for the state encoding
- One sub-module: bp_fe_credit_counter, an up/down counter with clear, width $clog2(fq_credits_p+1). It is reusable by the issue queue.

Test Plan:
- Reset release, then cmd_v_i pc=0x8000_0000 count=0 → same cycle: cmd_yumi_o=1, redirect_v_o=1, sel=2. Two refill cycles with ready=0, then ready=1, sel=0.
- Resume redirect with count=1, instr=0x4501 → redirect_count_o=1, redirect_instr_o=0x4501 in the pulse cycle only.
- Eight back-to-back fetch_instr_v_i with no returns → credits_o reaches 0 and the state enters e_stall (ready=0). One fq_credit_return_i → ready=1 the next cycle.
- fetch_rebase_i and fetch_catchup_i together, fetch_pc_i=0x8000_0042 → sel=3; next cycle ready=0, rebase_pc_o=0x8000_0042; then e_run.
- cmd_v_i coincident with fetch_rebase_i and fq_credit_return_i → redirect wins (sel=2), credits +1, no e_rebase.
- fq_clear_i with credits=3 plus a same-cycle fetch_instr_v_i → credits=8. reset_n_i pulsed during refill → state e_wait, all valid outputs 0 immediately.
